// File: rtl/ibex_dmem_pkg.sv
// Shared types and helpers for the Ibex data-memory responder.
package ibex_dmem_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_resp_t;

    // Word addresses keep the compare free of byte-offset bits and of base+size overflow.
    function automatic logic addr_in_range(input logic [29:0] addr_w,
                                           input logic [29:0] base_w,
                                           input int unsigned words);
        return (addr_w >= base_w) && ({2'b00, addr_w - base_w} < words);
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ibex_dmem_resp_fifo.sv
// In-order response queue with per-entry age; emits each response RespLatency edges after its push.
module ibex_dmem_resp_fifo
    import ibex_dmem_pkg::*;
#(
    parameter int unsigned Depth       = 2,
    parameter int unsigned RespLatency = 1,
    parameter int unsigned CntW        = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  dmem_resp_t      push_data_i,
    output logic [CntW-1:0] count_o,
    output logic            resp_valid_o,
    output dmem_resp_t      resp_o
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned     AgeW    = $clog2(RespLatency + 1);
    localparam logic [AgeW-1:0] HeadAge = (RespLatency >= 2) ? AgeW'(RespLatency - 2) : '0;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam bit              Bypass  = (RespLatency == 1);

    dmem_resp_t        data_q [Depth];
    dmem_resp_t        data_d [Depth];
    logic [AgeW-1:0]   age_q  [Depth];
    logic [AgeW-1:0]   age_d  [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   stored;
    logic              head_ready;
    logic              store_push;
    logic              resp_valid_q, resp_valid_d;
    dmem_resp_t        resp_q, resp_d;

    // An entry keeps its slot until its rvalid cycle ends, so the response
    // register counts toward occupancy while storage already holds one less.
    always_comb begin
        stored       = count_q - CntW'(resp_valid_q);
        head_ready   = !Bypass && (stored != '0) && (age_q[rd_ptr_q] == HeadAge);
        store_push   = push_i && !Bypass;
        resp_valid_d = head_ready || (Bypass && push_i);

        resp_d = '0;
        if (head_ready) begin
            resp_d = data_q[rd_ptr_q];
        end else if (Bypass && push_i) begin
            resp_d = push_data_i;
        end

        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < Depth; i++) begin
            age_d[i] = age_q[i] + AgeW'(1);
        end

        if (store_push) begin
            data_d[wr_ptr_q] = push_data_i;
            age_d[wr_ptr_q]  = '0;
            wr_ptr_d         = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (head_ready) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
        end

        count_d = count_q + CntW'(push_i) - CntW'(resp_valid_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
                age_q[i]  <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            data_q       <= data_d;
            age_q        <= age_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
        end
    end

    assign count_o      = count_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_o       = resp_q;

endmodule

// File: rtl/ibex_dmem_responder.sv
// Data-memory responder for the Ibex LSU: grant stall, backing array, ordered fixed-latency responses.
module ibex_dmem_responder
    import ibex_dmem_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned GntStall       = 0,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned       StallW   = (GntStall > 0) ? $clog2(GntStall + 1) : 1;
    localparam int unsigned       CntW     = $clog2(MaxOutstanding + 1);
    localparam int unsigned       IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam logic [StallW-1:0] StallMax = StallW'(GntStall);
    localparam logic [CntW-1:0]   CntMax   = CntW'(MaxOutstanding);

    logic [StallW-1:0] stall_q, stall_d;
    logic [CntW-1:0]   count_q;
    logic              gnt;
    logic              in_range;
    logic [IdxW-1:0]   word_idx;
    logic [31:0]       mem_q [MemWords];
    logic [31:0]       mem_rdata;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    dmem_resp_t        push_resp;
    dmem_resp_t        resp_out;
    logic              addr_lsb_unused;

    // Byte offset within the word is a don't-care for a word-wide memory.
    assign addr_lsb_unused = ^data_addr_i[1:0];

    // Grant is masked during reset so the LSU never sees an accept while state is cleared.
    assign gnt = rst_ni && data_req_i && (stall_q == StallMax) && (count_q < CntMax);

    always_comb begin
        stall_d = stall_q;
        if (!data_req_i || gnt) begin
            stall_d = '0;
        end else if (stall_q != StallMax) begin
            stall_d = stall_q + StallW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    always_comb begin
        in_range  = addr_in_range(data_addr_i[31:2], BaseAddr[31:2], MemWords);
        word_idx  = IdxW'(data_addr_i[31:2] - BaseAddr[31:2]);
        mem_rdata = mem_q[word_idx];
        mem_wdata = be_merge(mem_rdata, data_wdata_i, data_be_i);
        mem_we    = gnt && data_we_i && in_range;

        push_resp.rdata = (in_range && !data_we_i) ? mem_rdata : 32'h0;
        push_resp.err   = !in_range;
    end

    // Backing array is deliberately not reset so data survives a core reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[word_idx] <= mem_wdata;
        end
    end

    ibex_dmem_resp_fifo #(
        .Depth       (MaxOutstanding),
        .RespLatency (RespLatency)
    ) u_resp_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (gnt),
        .push_data_i  (push_resp),
        .count_o      (count_q),
        .resp_valid_o (data_rvalid_o),
        .resp_o       (resp_out)
    );

    assign data_gnt_o   = gnt;
    assign data_rdata_o = resp_out.rdata;
    assign data_err_o   = resp_out.err;

endmodule
